// File: rtl/add_seq_arbiter_pkg.sv
// Shared constants, FSM state type and slice-count helper for the
// sequential add/subtract engine.
package add_seq_pkg;

  localparam int SLICE_W = 8;
  localparam int NREQ    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslices(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/add_seq_arbiter_if.sv
// Two request channels plus one valid/ready response channel of the
// shared add/subtract engine.
interface add_seq_arbiter_if #(
    parameter int WIDTH = 32
);

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req0_sub;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic             req1_sub;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_ovf;
    logic             rsp_id;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_sub,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin, req1_sub,
        input  req1_ready,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id, busy,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_sub,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_sub,
        output req1_ready,
        output rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id, busy,
        input  rsp_ready
    );

endinterface

// File: rtl/add_seq_arbiter_add8_slice.sv
// Combinational 8-bit ripple-carry adder cell shared by both requesters.
module add8_slice
    import add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/add_seq_arbiter.sv
// Round-robin shared multi-precision add/subtract: one 8-bit slice per cycle,
// LSB first, carry registered between slices.
module add_seq_arbiter
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    add_seq_arbiter_if.slave bus
);

    localparam int N  = nslices(WIDTH);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    state_t state, state_nxt;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][WIDTH-1:0] req_a;
    logic [NREQ-1:0][WIDTH-1:0] req_b;
    logic [NREQ-1:0]            req_cin;
    logic [NREQ-1:0]            req_sub;

    logic             grant;
    logic             last_grant;
    logic             accept;
    logic             last_slice;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_nxt;
    logic             c_q;
    logic             id_q;
    logic [KW-1:0]    k_q;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_sum;
    logic               sl_cout;

    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q;
    logic             rsp_ovf_q;
    logic             rsp_id_q;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_a     = {bus.req1_a,     bus.req0_a};
    assign req_b     = {bus.req1_b,     bus.req0_b};
    assign req_cin   = {bus.req1_cin,   bus.req0_cin};
    assign req_sub   = {bus.req1_sub,   bus.req0_sub};

    // On contention the requester that did not win last time gets the slot.
    always_comb begin
        grant = req_valid[1];
        if (req_valid[0] && req_valid[1])
            grant = ~last_grant;
    end

    assign accept         = (state == IDLE) && req_valid[grant];
    assign bus.req0_ready = (state == IDLE) && !grant;
    assign bus.req1_ready = (state == IDLE) &&  grant;
    assign last_slice     = (k_q == KW'(N - 1));

    assign sl_a = a_q[int'(k_q)*SLICE_W +: SLICE_W];
    assign sl_b = b_q[int'(k_q)*SLICE_W +: SLICE_W];

    add8_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (c_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    always_comb begin
        sum_nxt = sum_q;
        sum_nxt[int'(k_q)*SLICE_W +: SLICE_W] = sl_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last_slice)    state_nxt = DONE;
            DONE:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            c_q         <= 1'b0;
            id_q        <= 1'b0;
            k_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Subtract as A + ~B + 1 so the same cell serves both ops.
                        a_q        <= req_a[grant];
                        b_q        <= req_sub[grant] ? ~req_b[grant] : req_b[grant];
                        c_q        <= req_sub[grant] ? 1'b1 : req_cin[grant];
                        id_q       <= grant;
                        last_grant <= grant;
                        k_q        <= '0;
                    end
                end
                RUN: begin
                    sum_q <= sum_nxt;
                    c_q   <= sl_cout;
                    k_q   <= k_q + KW'(1);
                    if (last_slice) begin
                        rsp_valid_q <= 1'b1;
                        rsp_sum_q   <= sum_nxt;
                        rsp_cout_q  <= sl_cout;
                        rsp_ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (sum_nxt[WIDTH-1] != a_q[WIDTH-1]);
                        rsp_id_q    <= id_q;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) rsp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_add_seq_arbiter.sv
// Scoreboard bench for add_seq_arbiter: per-requester drivers, a cycle-level
// reference model of grant/latency, and arithmetic expectations from plain integers.
module tb_add_seq_arbiter;

    localparam int W = 32;
    localparam int N = W / 8;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
    } cmd_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rsp_ready = 1'b0;
    int   rdy_mode = 1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    add_seq_arbiter_if #(.WIDTH(W)) bus ();

    add_seq_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Requester drivers: hold valid while commands are queued, advance on accept.
    for (genvar k = 0; k < 2; k++) begin : g_drv
        cmd_t q[$];
        cmd_t cur;
        logic v;
        logic pend;
        logic rdy;
        int   waitc;
        if (k == 0) begin : g_r0
            assign rdy = bus.req0_ready;
        end else begin : g_r1
            assign rdy = bus.req1_ready;
        end
        initial begin
            v = 1'b0; pend = 1'b0; cur = '0; waitc = 0;
            forever begin
                @(negedge clk);
                if (pend) begin
                    if (rdy && !rst) pend = 1'b0;
                    else begin
                        waitc++;
                        if (waitc > 300) begin
                            errors++;
                            $display("FAIL accept_timeout req%0d", k);
                            pend = 1'b0;
                        end
                    end
                end
                @(posedge clk);
                #1;
                if (!pend) begin
                    if (q.size() > 0) begin
                        cur = q.pop_front(); v = 1'b1; pend = 1'b1; waitc = 0;
                    end else v = 1'b0;
                end
            end
        end
    end

    assign bus.req0_valid = g_drv[0].v;
    assign bus.req0_a     = g_drv[0].cur.a;
    assign bus.req0_b     = g_drv[0].cur.b;
    assign bus.req0_cin   = g_drv[0].cur.cin;
    assign bus.req0_sub   = g_drv[0].cur.sub;
    assign bus.req1_valid = g_drv[1].v;
    assign bus.req1_a     = g_drv[1].cur.a;
    assign bus.req1_b     = g_drv[1].cur.b;
    assign bus.req1_cin   = g_drv[1].cur.cin;
    assign bus.req1_sub   = g_drv[1].cur.sub;
    assign bus.rsp_ready  = rsp_ready;

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic exp_t model(input logic id, input cmd_t c);
        exp_t        e;
        longint      sa, sb, rs;
        logic [63:0] u;
        sa = longint'($signed(c.a));
        sb = longint'($signed(c.b));
        if (c.sub) begin
            e.sum  = c.a - c.b;
            e.cout = (c.a >= c.b);
            rs     = sa - sb;
        end else begin
            u      = {32'b0, c.a} + {32'b0, c.b} + {63'b0, c.cin};
            e.sum  = u[W-1:0];
            e.cout = u[W];
            rs     = sa + sb + longint'(c.cin);
        end
        e.ovf = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
        e.id  = id;
        return e;
    endfunction

    // Reference model: engine is free, counting N slice cycles, or holding a result.
    exp_t exp_q[$];
    logic m_free = 1'b1, m_done = 1'b0, m_last = 1'b1;
    int   m_cnt = 0;
    logic seen_rst = 1'b0, prev_rst = 1'b0;

    always @(negedge clk) begin
        logic       v0, v1, g;
        logic [1:0] exp_rdy;
        exp_t       e;
        v0 = g_drv[0].v;
        v1 = g_drv[1].v;
        g  = (v0 && v1) ? !m_last : v1;
        if (seen_rst) begin
            if (prev_rst)
                chk("reset_outputs",
                    {26'b0, bus.rsp_valid, bus.busy, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf, bus.rsp_id}, 64'b0);
            exp_rdy = m_free ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", {62'b0, bus.req1_ready, bus.req0_ready}, {62'b0, exp_rdy});
            chk("busy", {63'b0, bus.busy}, {63'b0, !m_free});
            chk("rsp_valid", {63'b0, bus.rsp_valid}, {63'b0, m_done});
            if (m_done && bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = exp_q[0];
                    chk("rsp_sum",  {32'b0, bus.rsp_sum},  {32'b0, e.sum});
                    chk("rsp_cout_ovf_id", {61'b0, bus.rsp_cout, bus.rsp_ovf, bus.rsp_id},
                        {61'b0, e.cout, e.ovf, e.id});
                end
            end
        end
        if (rst) begin
            seen_rst = 1'b1;
            m_free = 1'b1; m_done = 1'b0; m_cnt = 0; m_last = 1'b1;
            exp_q.delete();
        end else if (seen_rst) begin
            if (m_done) begin
                if (rsp_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    m_done = 1'b0; m_free = 1'b1;
                end
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_done = 1'b1;
            end else if (m_free && (g ? v1 : v0)) begin
                exp_q.push_back(model(g, g ? g_drv[1].cur : g_drv[0].cur));
                m_last = g; m_free = 1'b0; m_cnt = N;
            end
        end
        prev_rst = rst;
    end

    task automatic push(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        cmd_t c;
        c.a = a; c.b = b; c.cin = cin; c.sub = sub;
        if (k == 0) g_drv[0].q.push_back(c);
        else        g_drv[1].q.push_back(c);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(g_drv[0].q.size() == 0 && g_drv[1].q.size() == 0 && !g_drv[0].pend &&
                 !g_drv[1].pend && m_free && !m_done && exp_q.size() == 0)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                chk("idle_timeout", 64'd1, 64'd0);
                return;
            end
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        rdy_mode = 1;
        push(0, 32'h0000_00FF, 32'h1, 1'b0, 1'b0);
        wait_idle(100);
        push(1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        wait_idle(100);
        push(0, 32'd5, 32'd7, 1'b1, 1'b1);
        push(0, 32'd7, 32'd5, 1'b0, 1'b1);
        wait_idle(100);
        push(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        push(1, 32'h8000_0000, 32'h1, 1'b0, 1'b1);
        wait_idle(100);

        for (int i = 0; i < 4; i++) begin
            push(0, $urandom, $urandom, 1'($urandom), 1'($urandom));
            push(1, $urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        wait_idle(200);

        rdy_mode = 0;
        push(1, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
        repeat (N + 7) @(negedge clk);
        rdy_mode = 1;
        wait_idle(100);

        push(0, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        push(0, 32'd100, 32'd1, 1'b0, 1'b1);
        push(1, 32'd200, 32'd2, 1'b0, 1'b1);
        wait_idle(100);

        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: push(0, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
                1: push(1, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
                default: begin
                    push(0, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
                    push(1, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
                end
            endcase
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        wait_idle(3000);
        rdy_mode = 1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
